// File: rtl/ray_dispatcher.sv
// Ray-index dispatcher: hands frame indices 0..NUM_RAYS-1 to NUM_LANES ray-cast lanes,
// tracks per-lane busy state from issue/done handshakes and signals frame completion.
module ray_dispatcher #(
  parameter int NUM_RAYS  = 640,
  parameter int NUM_LANES = 2,
  parameter int IDX_W     = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic                       auto_restart,
  input  logic [NUM_LANES-1:0]       lane_done,
  output logic [NUM_LANES-1:0]       issue_valid,
  output logic [NUM_LANES*IDX_W-1:0] issue_index,
  output logic                       frame_busy,
  output logic                       frame_done,
  output logic                       start_dropped
);

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} state_t;

  localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(NUM_RAYS - 1);

  state_t               state;
  logic [IDX_W-1:0]     next_index;
  logic [NUM_LANES-1:0] lane_busy;
  logic [NUM_LANES-1:0] free_lanes;
  logic [NUM_LANES-1:0] pick;

  // Lowest free lane as a one-hot vector; selection uses the registered busy
  // state, so a lane released this cycle is only eligible next cycle.
  always_comb begin
    free_lanes = ~lane_busy;
    pick       = free_lanes & (~free_lanes + NUM_LANES'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      next_index    <= '0;
      lane_busy     <= '0;
      issue_valid   <= '0;
      issue_index   <= '0;
      frame_busy    <= 1'b0;
      frame_done    <= 1'b0;
      start_dropped <= 1'b0;
    end else begin
      issue_valid   <= '0;
      frame_done    <= 1'b0;
      // A start landing on the completion pulse is dropped as well.
      start_dropped <= frame_start && (frame_busy || frame_done);
      lane_busy     <= lane_busy & ~lane_done;

      case (state)
        IDLE: begin
          if (frame_start && !frame_done) begin
            state      <= DISPATCH;
            next_index <= '0;
            frame_busy <= 1'b1;
          end
        end

        DISPATCH: begin
          if (|pick) begin
            issue_valid <= pick;
            lane_busy   <= (lane_busy & ~lane_done) | pick;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
              if (pick[i]) issue_index[i*IDX_W +: IDX_W] <= next_index;
            end
            next_index <= next_index + IDX_W'(1);
            if (next_index == LAST_INDEX) state <= DRAIN;
          end
        end

        DRAIN: begin
          if (lane_busy == '0) begin
            frame_done <= 1'b1;
            if (auto_restart) begin
              state      <= DISPATCH;
              next_index <= '0;
            end else begin
              state      <= IDLE;
              frame_busy <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_dispatcher.sv
// Bench for ray_dispatcher: scoreboarded issue order plus directed handshake/timing scenarios.
module tb_ray_dispatcher;

  localparam int NR = 8;
  localparam int NL = 2;
  localparam int IW = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic            frame_start;
  logic            auto_restart;
  logic [NL-1:0]   lane_done;
  logic [NL-1:0]   issue_valid;
  logic [NL*IW-1:0] issue_index;
  logic            frame_busy;
  logic            frame_done;
  logic            start_dropped;

  always #5 clk = ~clk;

  ray_dispatcher #(.NUM_RAYS(NR), .NUM_LANES(NL), .IDX_W(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .auto_restart (auto_restart),
    .lane_done    (lane_done),
    .issue_valid  (issue_valid),
    .issue_index  (issue_index),
    .frame_busy   (frame_busy),
    .frame_done   (frame_done),
    .start_dropped(start_dropped)
  );

  typedef struct {int lane; int idx;} iss_t;

  iss_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   resp_en;
  int   resp_delay;
  int   cnt[NL];

  function automatic int lane_of(logic [NL-1:0] v);
    int r = -1;
    for (int l = NL - 1; l >= 0; l--) if (v[l]) r = l;
    return r;
  endfunction

  function automatic int idx_of(int lane);
    if (lane < 0) return -1;
    return int'(issue_index[lane*IW +: IW]);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Lane model: each issued ray returns lane_done resp_delay cycles later.
  task automatic respond;
    lane_done = '0;
    for (int l = 0; l < NL; l++) begin
      if (resp_en && issue_valid[l]) cnt[l] = resp_delay;
      else if (cnt[l] > 0) begin
        cnt[l]--;
        if (cnt[l] == 0) lane_done[l] = 1'b1;
      end
    end
  endtask

  task automatic do_reset;
    reset = 1'b1; frame_start = 1'b0; auto_restart = 1'b0; lane_done = '0;
    resp_en = 1'b0; resp_delay = 0;
    for (int l = 0; l < NL; l++) cnt[l] = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    bit quiet = 1'b1;
    bit found = 1'b0;
    reset = 1'b1; frame_start = 1'b0; auto_restart = 1'b0; lane_done = '0;
    resp_en = 1'b0;
    for (int l = 0; l < NL; l++) cnt[l] = 0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({issue_valid, issue_index, frame_busy, frame_done, start_dropped} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got valid=%b idx=%h busy=%b done=%b drop=%b, required all 0",
               issue_valid, issue_index, frame_busy, frame_done, start_dropped);
    end
    reset = 1'b0;
    tick();
    resp_en = 1'b1; resp_delay = 3;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (issue_valid != '0 && idx_of(lane_of(issue_valid)) == 5) found = 1'b1;
      else begin respond(); tick(); end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL reset_reach_idx5: got no issue of index 5, required one within 60 cycles");
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({issue_valid, issue_index, frame_busy, frame_done, start_dropped} !== '0) begin
      miscompares++;
      $display("FAIL reset_async: got valid=%b idx=%h busy=%b, required all 0 before next edge",
               issue_valid, issue_index, frame_busy);
    end
    resp_en = 1'b0; lane_done = '0;
    for (int l = 0; l < NL; l++) cnt[l] = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    lane_done = '1;
    tick();
    lane_done = '0;
    for (int c = 0; c < 3; c++) begin
      if (frame_busy !== 1'b0 || issue_valid !== '0) quiet = 1'b0;
      tick();
    end
    vectors++;
    if (!quiet) begin
      miscompares++;
      $display("FAIL reset_stale_done: got activity after stale lane_done, required idle");
    end
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    vectors++;
    if (frame_busy !== 1'b1 || issue_valid !== '0) begin
      miscompares++;
      $display("FAIL start_latency: got busy=%b valid=%b, required busy=1 valid=00", frame_busy, issue_valid);
    end
    tick();
    vectors++;
    if (issue_valid !== 2'b01 || idx_of(0) !== 0) begin
      miscompares++;
      $display("FAIL reset_restart_idx0: got valid=%b idx=%0d, required valid=01 idx=0",
               issue_valid, idx_of(0));
    end
  endtask

  task automatic test_basic_frame;
    iss_t e;
    int fd_n = 0, fd_cyc = -100, last_done = -100, sd_n = 0, issues = 0;
    do_reset();
    resp_en = 1'b1; resp_delay = 3;
    for (int i = 0; i < NR; i++) exp_q.push_back('{lane: i % NL, idx: i});
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int c = 0; c < 200 && !(fd_n > 0 && cyc > fd_cyc + 5); c++) begin
      if (issue_valid != '0) begin
        issues++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL basic_extra_issue: got valid=%b idx=%0d, required none",
                   issue_valid, idx_of(lane_of(issue_valid)));
        end else begin
          e = exp_q.pop_front();
          if (!$onehot(issue_valid) || lane_of(issue_valid) != e.lane || idx_of(e.lane) != e.idx) begin
            miscompares++;
            $display("FAIL basic_issue: got valid=%b idx=%0d, required lane %0d idx %0d",
                     issue_valid, idx_of(lane_of(issue_valid)), e.lane, e.idx);
          end
        end
      end
      if (frame_done) begin fd_n++; fd_cyc = cyc; end
      if (start_dropped) sd_n++;
      respond();
      if (lane_done != '0) last_done = cyc;
      tick();
    end
    vectors++;
    if (issues != NR || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL basic_issue_count: got %0d issues (%0d unissued), required %0d", issues, exp_q.size(), NR);
    end
    vectors++;
    if (fd_n != 1) begin
      miscompares++;
      $display("FAIL basic_done_count: got %0d frame_done pulses, required 1", fd_n);
    end
    vectors++;
    if (fd_cyc != last_done + 2) begin
      miscompares++;
      $display("FAIL basic_done_timing: got frame_done at cycle %0d, required %0d", fd_cyc, last_done + 2);
    end
    vectors++;
    if (frame_busy !== 1'b0 || sd_n != 0) begin
      miscompares++;
      $display("FAIL basic_idle_after: got busy=%b drops=%0d, required busy=0 drops=0", frame_busy, sd_n);
    end
  endtask

  task automatic test_simultaneous_done;
    do_reset();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick();
    vectors++;
    if (issue_valid !== 2'b01 || idx_of(0) !== 0) begin
      miscompares++;
      $display("FAIL simul_first: got valid=%b idx=%0d, required 01 idx 0", issue_valid, idx_of(0));
    end
    tick();
    vectors++;
    if (issue_valid !== 2'b10 || idx_of(1) !== 1) begin
      miscompares++;
      $display("FAIL simul_second: got valid=%b idx=%0d, required 10 idx 1", issue_valid, idx_of(1));
    end
    tick();
    lane_done = 2'b11;
    tick();
    lane_done = '0;
    vectors++;
    if (issue_valid !== 2'b00) begin
      miscompares++;
      $display("FAIL simul_no_same_cycle: got valid=%b, required 00", issue_valid);
    end
    tick();
    vectors++;
    if (issue_valid !== 2'b01 || idx_of(0) !== 2) begin
      miscompares++;
      $display("FAIL simul_l0_reissue: got valid=%b idx=%0d, required 01 idx 2", issue_valid, idx_of(0));
    end
    tick();
    vectors++;
    if (issue_valid !== 2'b10 || idx_of(1) !== 3) begin
      miscompares++;
      $display("FAIL simul_l1_reissue: got valid=%b idx=%0d, required 10 idx 3", issue_valid, idx_of(1));
    end
  endtask

  task automatic test_held_done;
    bit quiet = 1'b1;
    do_reset();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick(); tick(); tick();
    lane_done = 2'b10;
    tick();
    vectors++;
    if (issue_valid !== 2'b00) begin
      miscompares++;
      $display("FAIL held_no_issue: got valid=%b, required 00", issue_valid);
    end
    tick();
    lane_done = '0;
    vectors++;
    if (issue_valid !== 2'b10 || idx_of(1) !== 2) begin
      miscompares++;
      $display("FAIL held_issue_next: got valid=%b idx=%0d, required 10 idx 2", issue_valid, idx_of(1));
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (issue_valid !== '0) quiet = 1'b0;
    end
    vectors++;
    if (!quiet) begin
      miscompares++;
      $display("FAIL held_lane1_busy: got an issue while both lanes busy, required none");
    end
    lane_done = 2'b01;
    tick();
    lane_done = '0;
    tick();
    vectors++;
    if (issue_valid !== 2'b01 || idx_of(0) !== 3) begin
      miscompares++;
      $display("FAIL held_l0_next: got valid=%b idx=%0d, required 01 idx 3", issue_valid, idx_of(0));
    end
  endtask

  task automatic test_auto_restart;
    iss_t e;
    int fd_n = 0, fd_cyc = -100;
    do_reset();
    resp_en = 1'b1; resp_delay = 2; auto_restart = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < NR; i++) exp_q.push_back('{lane: i % NL, idx: i});
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int c = 0; c < 400 && !(fd_n > 1 && cyc > fd_cyc + 4); c++) begin
      if (fd_n == 1 && cyc == fd_cyc + 1) begin
        vectors++;
        if (issue_valid !== 2'b01 || idx_of(0) !== 0 || frame_busy !== 1'b1) begin
          miscompares++;
          $display("FAIL auto_first_issue: got valid=%b idx=%0d busy=%b, required 01 idx 0 busy 1",
                   issue_valid, idx_of(0), frame_busy);
        end
      end
      if (issue_valid != '0) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL auto_extra_issue: got valid=%b, required none", issue_valid);
        end else begin
          e = exp_q.pop_front();
          if (!$onehot(issue_valid) || lane_of(issue_valid) != e.lane || idx_of(e.lane) != e.idx) begin
            miscompares++;
            $display("FAIL auto_issue: got valid=%b idx=%0d, required lane %0d idx %0d",
                     issue_valid, idx_of(lane_of(issue_valid)), e.lane, e.idx);
          end
        end
      end
      if (frame_done) begin
        fd_n++; fd_cyc = cyc;
        vectors++;
        if (frame_busy !== (fd_n == 1)) begin
          miscompares++;
          $display("FAIL auto_busy_at_done%0d: got busy=%b, required %b", fd_n, frame_busy, fd_n == 1);
        end
        auto_restart = 1'b0;
      end
      respond();
      tick();
    end
    vectors++;
    if (fd_n != 2 || exp_q.size() != 0 || frame_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL auto_two_frames: got %0d done pulses, %0d unissued, busy=%b, required 2, 0, 0",
               fd_n, exp_q.size(), frame_busy);
    end
  endtask

  task automatic test_start_dropped;
    iss_t e;
    int fd_n = 0, fd_cyc = -100, sd_n = 0;
    do_reset();
    resp_en = 1'b1; resp_delay = 3;
    for (int i = 0; i < NR; i++) exp_q.push_back('{lane: i % NL, idx: i});
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int c = 0; c < 200 && !(fd_n > 0 && cyc > fd_cyc + 6); c++) begin
      frame_start = 1'b0;
      if (start_dropped) sd_n++;
      if (issue_valid != '0) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL drop_extra_issue: got valid=%b idx=%0d, required none",
                   issue_valid, idx_of(lane_of(issue_valid)));
        end else begin
          e = exp_q.pop_front();
          if (!$onehot(issue_valid) || lane_of(issue_valid) != e.lane || idx_of(e.lane) != e.idx) begin
            miscompares++;
            $display("FAIL drop_issue: got valid=%b idx=%0d, required lane %0d idx %0d",
                     issue_valid, idx_of(lane_of(issue_valid)), e.lane, e.idx);
          end
          if (e.idx == NR - 1) frame_start = 1'b1;
        end
      end
      if (frame_done) begin fd_n++; fd_cyc = cyc; frame_start = 1'b1; end
      respond();
      tick();
    end
    frame_start = 1'b0;
    vectors++;
    if (sd_n != 2) begin
      miscompares++;
      $display("FAIL drop_count: got %0d start_dropped pulses, required 2", sd_n);
    end
    vectors++;
    if (fd_n != 1 || frame_busy !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drop_no_new_frame: got %0d done pulses busy=%b, required 1 and busy=0", fd_n, frame_busy);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_simultaneous_done();
    test_held_done();
    test_auto_restart();
    test_start_dropped();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
